timer_controller: RTL and testbench

Sequencing controller for the countdown Timer in the Morse decoder. It latches a requested countdown mode, pulses the Timer's reconfig to load the digits, and gates the Timer's enable through run, pause and abort. It tracks the remaining seconds by counting the Timer's 1-second timeout pulses. It flags a warning near the end and reports expiry, so the decoder's symbol and word logic can time out without reading the seven-segment digits.

---
 rtl/timer_controller.sv | 156 +++++++++++++++
 tb/tb_timer_controller.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_controller.sv
// timer_controller: sequences the countdown Timer (load, run, pause, abort),
// tracks remaining seconds from the Timer's 1-second pulses and reports
// low-time warning and expiry. Every output comes straight from a flop.
//
// state    | meaning
// ---------+----------------------------------------------------------
// IDLE     | waiting for start; Timer disabled
// LOAD     | one-cycle reconfig pulse so the Timer picks up timer_mode
// RUN      | Timer enabled; each timeout_1sec takes one second off
// PAUSE    | Timer disabled; seconds_left frozen until pause again
// EXPIRED  | countdown reached 0; waits for a new start or abort
module timer_controller #(
  parameter int PRESET0   = 10,
  parameter int PRESET1   = 30,
  parameter int PRESET2   = 60,
  parameter int PRESET3   = 99,
  parameter int WARN_SECS = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       pause,
  input  logic       abort,
  input  logic [1:0] mode_sel,
  input  logic       timeout_1sec,
  output logic       timer_enable,
  output logic       timer_reconfig,
  output logic [1:0] timer_mode,
  output logic [6:0] seconds_left,
  output logic       busy,
  output logic       warn,
  output logic       done,
  output logic       expired,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_RUN     = 3'd2,
    S_PAUSE   = 3'd3,
    S_EXPIRED = 3'd4
  } state_t;

  // The two-digit display cannot show more than 99 seconds.
  localparam int P0_C = (PRESET0 > 99) ? 99 : ((PRESET0 < 0) ? 0 : PRESET0);
  localparam int P1_C = (PRESET1 > 99) ? 99 : ((PRESET1 < 0) ? 0 : PRESET1);
  localparam int P2_C = (PRESET2 > 99) ? 99 : ((PRESET2 < 0) ? 0 : PRESET2);
  localparam int P3_C = (PRESET3 > 99) ? 99 : ((PRESET3 < 0) ? 0 : PRESET3);
  localparam int W_C  = (WARN_SECS > 99) ? 99 : ((WARN_SECS < 0) ? 0 : WARN_SECS);

  localparam logic [6:0] P0     = 7'(P0_C);
  localparam logic [6:0] P1     = 7'(P1_C);
  localparam logic [6:0] P2     = 7'(P2_C);
  localparam logic [6:0] P3     = 7'(P3_C);
  localparam logic [6:0] WARN_L = 7'(W_C);

  state_t     state_q;
  state_t     state_nxt;
  logic [6:0] secs_nxt;
  logic [1:0] mode_nxt;
  logic [6:0] preset_sel;
  logic       warn_nxt;
  logic       done_nxt;

  // Preset lookup for the requested mode.
  always_comb begin
    preset_sel = P0;
    case (mode_sel)
      2'b00:   preset_sel = P0;
      2'b01:   preset_sel = P1;
      2'b10:   preset_sel = P2;
      default: preset_sel = P3;
    endcase
  end

  // Next-state and next-count logic; priority abort > start > pause > timeout.
  always_comb begin
    state_nxt = state_q;
    secs_nxt  = seconds_left;
    mode_nxt  = timer_mode;
    if (abort) begin
      state_nxt = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE, S_EXPIRED: begin
          if (start) begin
            state_nxt = S_LOAD;
            mode_nxt  = mode_sel;
            secs_nxt  = preset_sel;
          end
        end
        S_LOAD: begin
          state_nxt = (seconds_left == 7'd0) ? S_EXPIRED : S_RUN;
        end
        S_RUN: begin
          if (pause) begin
            state_nxt = S_PAUSE;
          end else if (timeout_1sec) begin
            // Treat 0 like 1 so the count can never wrap.
            if (seconds_left <= 7'd1) begin
              secs_nxt  = 7'd0;
              state_nxt = S_EXPIRED;
            end else begin
              secs_nxt = seconds_left - 7'd1;
            end
          end
        end
        S_PAUSE: begin
          if (pause) state_nxt = S_RUN;
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // Derived outputs are computed from the next state so they flop in step with it.
  always_comb begin
    warn_nxt = ((state_nxt == S_RUN) || (state_nxt == S_PAUSE)) &&
               (secs_nxt != 7'd0) && (secs_nxt <= WARN_L);
    done_nxt = (state_nxt == S_EXPIRED) && (state_q != S_EXPIRED);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_nxt;
  end

  // Registered outputs and countdown value.
  always_ff @(posedge clk) begin
    if (rst) begin
      timer_enable   <= 1'b0;
      timer_reconfig <= 1'b0;
      timer_mode     <= 2'b00;
      seconds_left   <= 7'd0;
      busy           <= 1'b0;
      warn           <= 1'b0;
      done           <= 1'b0;
      expired        <= 1'b0;
    end else begin
      timer_enable   <= (state_nxt == S_RUN);
      timer_reconfig <= (state_nxt == S_LOAD);
      timer_mode     <= mode_nxt;
      seconds_left   <= secs_nxt;
      busy           <= (state_nxt == S_LOAD) || (state_nxt == S_RUN) ||
                        (state_nxt == S_PAUSE);
      warn           <= warn_nxt;
      done           <= done_nxt;
      expired        <= (state_nxt == S_EXPIRED);
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_timer_controller.sv
// Scoreboard bench for timer_controller: each step pushes the expected
// output snapshot, advances one clock and compares the popped entry.
module tb_timer_controller;

  typedef struct packed {
    logic [2:0] st;
    logic       en;
    logic       rc;
    logic [1:0] md;
    logic [6:0] secs;
    logic       busy;
    logic       warn;
    logic       done;
    logic       expd;
  } obs_t;

  localparam int WARN = 5;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       pause = 1'b0;
  logic       abort = 1'b0;
  logic       timeout_1sec = 1'b0;
  logic [1:0] mode_sel = 2'b00;

  logic       a_en, a_rc, a_busy, a_warn, a_done, a_expd;
  logic [1:0] a_md;
  logic [6:0] a_secs;
  logic [2:0] a_st;
  logic       z_en, z_rc, z_busy, z_warn, z_done, z_expd;
  logic [1:0] z_md;
  logic [6:0] z_secs;
  logic [2:0] z_st;

  int   total = 0;
  int   passed = 0;
  obs_t exp_q[$];
  obs_t got, want;

  timer_controller dut (
    .clk(clk), .rst(rst), .start(start), .pause(pause), .abort(abort),
    .mode_sel(mode_sel), .timeout_1sec(timeout_1sec),
    .timer_enable(a_en), .timer_reconfig(a_rc), .timer_mode(a_md),
    .seconds_left(a_secs), .busy(a_busy), .warn(a_warn), .done(a_done),
    .expired(a_expd), .state(a_st)
  );

  timer_controller #(.PRESET0(0), .PRESET3(150)) dut_z (
    .clk(clk), .rst(rst), .start(start), .pause(pause), .abort(abort),
    .mode_sel(mode_sel), .timeout_1sec(timeout_1sec),
    .timer_enable(z_en), .timer_reconfig(z_rc), .timer_mode(z_md),
    .seconds_left(z_secs), .busy(z_busy), .warn(z_warn), .done(z_done),
    .expired(z_expd), .state(z_st)
  );

  always #5 clk = ~clk;

  function automatic obs_t sample_a();
    obs_t o;
    o.st = a_st; o.en = a_en; o.rc = a_rc; o.md = a_md; o.secs = a_secs;
    o.busy = a_busy; o.warn = a_warn; o.done = a_done; o.expd = a_expd;
    return o;
  endfunction

  function automatic obs_t sample_z();
    obs_t o;
    o.st = z_st; o.en = z_en; o.rc = z_rc; o.md = z_md; o.secs = z_secs;
    o.busy = z_busy; o.warn = z_warn; o.done = z_done; o.expd = z_expd;
    return o;
  endfunction

  function automatic obs_t e_idle(input logic [1:0] md, input int s);
    obs_t o;
    o = '0; o.st = 3'd0; o.md = md; o.secs = 7'(s);
    return o;
  endfunction

  function automatic obs_t e_load(input logic [1:0] md, input int s);
    obs_t o;
    o = '0; o.st = 3'd1; o.rc = 1'b1; o.md = md; o.secs = 7'(s); o.busy = 1'b1;
    return o;
  endfunction

  function automatic obs_t e_run(input logic [1:0] md, input int s);
    obs_t o;
    o = '0; o.st = 3'd2; o.en = 1'b1; o.md = md; o.secs = 7'(s); o.busy = 1'b1;
    o.warn = (s > 0) && (s <= WARN);
    return o;
  endfunction

  function automatic obs_t e_pause(input logic [1:0] md, input int s);
    obs_t o;
    o = '0; o.st = 3'd3; o.md = md; o.secs = 7'(s); o.busy = 1'b1;
    o.warn = (s > 0) && (s <= WARN);
    return o;
  endfunction

  function automatic obs_t e_exp(input logic [1:0] md, input logic d);
    obs_t o;
    o = '0; o.st = 3'd4; o.md = md; o.done = d; o.expd = 1'b1;
    return o;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    exp_q.push_back(e_idle(2'b00, 0));
    tick();
    rst = 1'b0;
    got = sample_a(); want = exp_q.pop_front(); total++;
    if (got !== want) $display("FAIL reset got=%h exp=%h", got, want); else passed++;
  endtask

  task automatic test_mode0();
    start = 1'b1; mode_sel = 2'b00;
    exp_q.push_back(e_load(2'b00, 10));
    tick();
    start = 1'b0;
    got = sample_a(); want = exp_q.pop_front(); total++;
    if (got !== want) $display("FAIL mode0_load got=%h exp=%h", got, want); else passed++;
    exp_q.push_back(e_run(2'b00, 10));
    tick();
    got = sample_a(); want = exp_q.pop_front(); total++;
    if (got !== want) $display("FAIL mode0_run got=%h exp=%h", got, want); else passed++;
    for (int i = 1; i <= 10; i++) begin
      timeout_1sec = 1'b1;
      exp_q.push_back((i < 10) ? e_run(2'b00, 10 - i) : e_exp(2'b00, 1'b1));
      tick();
      got = sample_a(); want = exp_q.pop_front(); total++;
      if (got !== want) $display("FAIL mode0_pulse%0d got=%h exp=%h", i, got, want); else passed++;
    end
    timeout_1sec = 1'b0;
    exp_q.push_back(e_exp(2'b00, 1'b0));
    tick();
    got = sample_a(); want = exp_q.pop_front(); total++;
    if (got !== want) $display("FAIL mode0_done_clear got=%h exp=%h", got, want); else passed++;
  endtask

  task automatic test_warn();
    start = 1'b1; mode_sel = 2'b11;
    exp_q.push_back(e_load(2'b11, 99));
    tick();
    start = 1'b0;
    got = sample_a(); want = exp_q.pop_front(); total++;
    if (got !== want) $display("FAIL mode3_load got=%h exp=%h", got, want); else passed++;
    exp_q.push_back(e_run(2'b11, 99));
    tick();
    got = sample_a(); want = exp_q.pop_front(); total++;
    if (got !== want) $display("FAIL mode3_run got=%h exp=%h", got, want); else passed++;
    for (int i = 1; i <= 99; i++) begin
      timeout_1sec = 1'b1;
      exp_q.push_back((i < 99) ? e_run(2'b11, 99 - i) : e_exp(2'b11, 1'b1));
      tick();
      got = sample_a(); want = exp_q.pop_front(); total++;
      if (got !== want) $display("FAIL warn_pulse%0d got=%h exp=%h", i, got, want); else passed++;
    end
    timeout_1sec = 1'b0;
  endtask

  task automatic test_pause();
    start = 1'b1; mode_sel = 2'b01;
    exp_q.push_back(e_load(2'b01, 30));
    tick();
    start = 1'b0;
    got = sample_a(); want = exp_q.pop_front(); total++;
    if (got !== want) $display("FAIL pause_load got=%h exp=%h", got, want); else passed++;
    exp_q.push_back(e_run(2'b01, 30));
    tick();
    got = sample_a(); want = exp_q.pop_front(); total++;
    if (got !== want) $display("FAIL pause_run got=%h exp=%h", got, want); else passed++;
    for (int i = 1; i <= 10; i++) begin
      timeout_1sec = 1'b1;
      exp_q.push_back(e_run(2'b01, 30 - i));
      tick();
      got = sample_a(); want = exp_q.pop_front(); total++;
      if (got !== want) $display("FAIL pause_count%0d got=%h exp=%h", i, got, want); else passed++;
    end
    timeout_1sec = 1'b0;
    pause = 1'b1;
    exp_q.push_back(e_pause(2'b01, 20));
    tick();
    pause = 1'b0;
    got = sample_a(); want = exp_q.pop_front(); total++;
    if (got !== want) $display("FAIL pause_enter got=%h exp=%h", got, want); else passed++;
    for (int i = 1; i <= 3; i++) begin
      timeout_1sec = 1'b1;
      exp_q.push_back(e_pause(2'b01, 20));
      tick();
      got = sample_a(); want = exp_q.pop_front(); total++;
      if (got !== want) $display("FAIL pause_hold%0d got=%h exp=%h", i, got, want); else passed++;
    end
    timeout_1sec = 1'b0;
    pause = 1'b1;
    exp_q.push_back(e_run(2'b01, 20));
    tick();
    pause = 1'b0;
    got = sample_a(); want = exp_q.pop_front(); total++;
    if (got !== want) $display("FAIL pause_resume got=%h exp=%h", got, want); else passed++;
    for (int i = 1; i <= 12; i++) begin
      timeout_1sec = 1'b1;
      exp_q.push_back(e_run(2'b01, 20 - i));
      tick();
      got = sample_a(); want = exp_q.pop_front(); total++;
      if (got !== want) $display("FAIL resume_count%0d got=%h exp=%h", i, got, want); else passed++;
    end
    pause = 1'b1; timeout_1sec = 1'b1;
    exp_q.push_back(e_pause(2'b01, 8));
    tick();
    pause = 1'b0;
    got = sample_a(); want = exp_q.pop_front(); total++;
    if (got !== want) $display("FAIL pause_vs_timeout got=%h exp=%h", got, want); else passed++;
    exp_q.push_back(e_pause(2'b01, 8));
    tick();
    timeout_1sec = 1'b0;
    got = sample_a(); want = exp_q.pop_front(); total++;
    if (got !== want) $display("FAIL pause_hold8 got=%h exp=%h", got, want); else passed++;
    pause = 1'b1;
    exp_q.push_back(e_run(2'b01, 8));
    tick();
    pause = 1'b0;
    got = sample_a(); want = exp_q.pop_front(); total++;
    if (got !== want) $display("FAIL pause_resume8 got=%h exp=%h", got, want); else passed++;
  endtask

  task automatic test_abort();
    abort = 1'b1;
    exp_q.push_back(e_idle(2'b01, 8));
    tick();
    abort = 1'b0;
    got = sample_a(); want = exp_q.pop_front(); total++;
    if (got !== want) $display("FAIL abort_run got=%h exp=%h", got, want); else passed++;
    start = 1'b1; mode_sel = 2'b01;
    exp_q.push_back(e_load(2'b01, 30));
    tick();
    start = 1'b0;
    got = sample_a(); want = exp_q.pop_front(); total++;
    if (got !== want) $display("FAIL abort_reload got=%h exp=%h", got, want); else passed++;
    exp_q.push_back(e_run(2'b01, 30));
    tick();
    got = sample_a(); want = exp_q.pop_front(); total++;
    if (got !== want) $display("FAIL abort_run30 got=%h exp=%h", got, want); else passed++;
    for (int i = 1; i <= 15; i++) begin
      timeout_1sec = 1'b1;
      exp_q.push_back(e_run(2'b01, 30 - i));
      tick();
      got = sample_a(); want = exp_q.pop_front(); total++;
      if (got !== want) $display("FAIL abort_count%0d got=%h exp=%h", i, got, want); else passed++;
    end
    timeout_1sec = 1'b0;
    start = 1'b1; mode_sel = 2'b00;
    exp_q.push_back(e_run(2'b01, 15));
    tick();
    start = 1'b0;
    got = sample_a(); want = exp_q.pop_front(); total++;
    if (got !== want) $display("FAIL start_ignored got=%h exp=%h", got, want); else passed++;
    abort = 1'b1;
    exp_q.push_back(e_idle(2'b01, 15));
    tick();
    got = sample_a(); want = exp_q.pop_front(); total++;
    if (got !== want) $display("FAIL abort_at15 got=%h exp=%h", got, want); else passed++;
    start = 1'b1; mode_sel = 2'b10;
    exp_q.push_back(e_idle(2'b01, 15));
    tick();
    abort = 1'b0;
    got = sample_a(); want = exp_q.pop_front(); total++;
    if (got !== want) $display("FAIL abort_over_start got=%h exp=%h", got, want); else passed++;
    mode_sel = 2'b01;
    exp_q.push_back(e_load(2'b01, 30));
    tick();
    start = 1'b0;
    got = sample_a(); want = exp_q.pop_front(); total++;
    if (got !== want) $display("FAIL restart_mode1 got=%h exp=%h", got, want); else passed++;
    exp_q.push_back(e_run(2'b01, 30));
    tick();
    got = sample_a(); want = exp_q.pop_front(); total++;
    if (got !== want) $display("FAIL restart_run got=%h exp=%h", got, want); else passed++;
    rst = 1'b1;
    exp_q.push_back(e_idle(2'b00, 0));
    tick();
    rst = 1'b0;
    got = sample_a(); want = exp_q.pop_front(); total++;
    if (got !== want) $display("FAIL reset_midcount got=%h exp=%h", got, want); else passed++;
  endtask

  task automatic test_zero_preset();
    start = 1'b1; mode_sel = 2'b00;
    exp_q.push_back(e_load(2'b00, 0));
    tick();
    start = 1'b0;
    got = sample_z(); want = exp_q.pop_front(); total++;
    if (got !== want) $display("FAIL zero_load got=%h exp=%h", got, want); else passed++;
    exp_q.push_back(e_exp(2'b00, 1'b1));
    tick();
    got = sample_z(); want = exp_q.pop_front(); total++;
    if (got !== want) $display("FAIL zero_expire got=%h exp=%h", got, want); else passed++;
    exp_q.push_back(e_exp(2'b00, 1'b0));
    tick();
    got = sample_z(); want = exp_q.pop_front(); total++;
    if (got !== want) $display("FAIL zero_done_clear got=%h exp=%h", got, want); else passed++;
    start = 1'b1; mode_sel = 2'b11;
    exp_q.push_back(e_load(2'b11, 99));
    tick();
    start = 1'b0;
    got = sample_z(); want = exp_q.pop_front(); total++;
    if (got !== want) $display("FAIL clamp_load got=%h exp=%h", got, want); else passed++;
    exp_q.push_back(e_run(2'b11, 99));
    tick();
    got = sample_z(); want = exp_q.pop_front(); total++;
    if (got !== want) $display("FAIL clamp_run got=%h exp=%h", got, want); else passed++;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired before the test sequence finished");
    $fatal(1, "watchdog");
  end

  initial begin
    #1;
    test_reset();
    test_mode0();
    test_warn();
    test_pause();
    test_abort();
    test_zero_preset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
